// File: rtl/ram_stream_reader_pkg.sv
// Shared types and sizing for the RAM stream reader.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Two-entry output skid buffer; a push into a full buffer with a pop reuses the popped slot.
module ram_stream_reader_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] pushData,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] headData,
    output logic [OCC_W-1:0]      occupancy
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [OCC_W-1:0]      count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= pushData;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign headData  = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a RAM address range and streams the words out with valid/ready backpressure.
// Optional RAM_STREAM_READER_ABORT_EN adds an abort input that cancels a transfer.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned LOAD_W = OCC_W + 1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] read_addr_q;
    logic [CNT_W-1:0]      remaining_q;
    logic                  inflight_q;
    logic                  busy_q;
    logic                  done_q;

    logic [OCC_W-1:0]      occupancy;
    logic [LOAD_W-1:0]     load_c;
    logic                  pop_c;
    logic                  issue_c;
    logic                  abort_c;

`ifdef RAM_STREAM_READER_ABORT_EN
    assign abort_c = abort && (state_q != IDLE);
`else
    assign abort_c = 1'b0;
`endif

    // Words that will occupy the buffer once everything in flight has landed.
    assign pop_c   = outValid && outReady;
    assign load_c  = LOAD_W'(occupancy) + LOAD_W'(inflight_q) - LOAD_W'(pop_c);
    assign issue_c = (state_q == READ) && (remaining_q != '0) && !abort_c
                     && (load_c < LOAD_W'(SKID_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            read_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue_c;
            if (issue_c) begin
                read_addr_q <= read_addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= READ;
                            busy_q      <= 1'b1;
                            read_addr_q <= baseAddr;
                            remaining_q <= length;
                        end
                    end
                end
                READ: begin
                    if (issue_c && (remaining_q == CNT_W'(1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last word is the only one left and it is leaving now.
                    if (!inflight_q && (occupancy == OCC_W'(1)) && pop_c) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (abort_c) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                inflight_q <= 1'b0;
            end
        end
    end

    ram_stream_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort_c),
        .push      (inflight_q && !abort_c),
        .pushData  (q),
        .pop       (pop_c),
        .headData  (outData),
        .occupancy (occupancy)
    );

    assign outValid  = (occupancy != '0);
    assign read_addr = read_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader; RAM_STREAM_READER_ABORT_EN adds the abort scenario.
module tb_ram_stream_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] baseAddr;
    logic [6:0] length;
    logic [5:0] read_addr;
    logic [7:0] q;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       busy;
    logic       done;
`ifdef RAM_STREAM_READER_ABORT_EN
    logic       abort;
`endif

    logic [7:0] ram [64];
    logic [7:0] got [$];
    int         checks = 0;
    int         failures = 0;
    int         done_cnt, stab_err, valid_seen;
    bit         busy_seen;
    bit         prev_v, prev_r;
    logic [7:0] prev_d;

    ram_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .baseAddr  (baseAddr),
        .length    (length),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort     (abort),
`endif
        .read_addr (read_addr),
        .q         (q),
        .outData   (outData),
        .outValid  (outValid),
        .outReady  (outReady),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model.
    always @(posedge clk) q <= ram[read_addr];

    // Stream observer: collects handshakes and watches hold-under-stall.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (outValid && outReady) got.push_back(outData);
            if (done) done_cnt++;
            if (busy) busy_seen = 1'b1;
            if (outValid) valid_seen++;
            if (prev_v && !prev_r && (!outValid || outData !== prev_d)) stab_err++;
            prev_v = outValid;
            prev_r = outReady;
            prev_d = outData;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input int base, input int len, input int mode, input string tag);
        int cyc = 0;
        int stall = 0;
        bit seen = 1'b0;
        got.delete();
        done_cnt   = 0;
        stab_err   = 0;
        valid_seen = 0;
        busy_seen  = 1'b0;
        baseAddr   = 6'(base);
        length     = 7'(len);
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && cyc < 2000) begin
            if (mode == 0) outReady = 1'b1;
            else if (stall > 0) begin outReady = 1'b0; stall--; end
            else if ($urandom_range(15) == 0) begin outReady = 1'b0; stall = 9; end
            else outReady = 1'($urandom_range(1));
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, " done_seen"}, 32'(seen), 1);
        check({tag, " words"}, 32'(got.size()), 32'(len));
        for (int i = 0; i < len; i++) begin
            if (i < got.size()) check({tag, " data"}, 32'(got[i]), 32'(ram[6'(base + i)]));
        end
        check({tag, " done_pulses"}, 32'(done_cnt), 1);
        check({tag, " stall_hold"}, 32'(stab_err), 0);
        check({tag, " busy_seen"}, 32'(busy_seen), 32'(len != 0));
        if (len == 0) check({tag, " no_valid"}, 32'(valid_seen), 0);
        check({tag, " busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        length   = '0;
        outReady = 1'b0;
`ifdef RAM_STREAM_READER_ABORT_EN
        abort    = 1'b0;
`endif
        for (int i = 0; i < 64; i++) ram[i] = 8'(i * 3);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst read_addr", 32'(read_addr), 0);
        check("rst outData", 32'(outData), 0);
        check("rst outValid", 32'(outValid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed timing: base 4, length 5, always ready.
        baseAddr = 6'd4;
        length   = 7'd5;
        outReady = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("t1 busy_after_start", 32'(busy), 1);
        check("t1 read_addr_base", 32'(read_addr), 4);
        @(negedge clk);
        check("t1 valid_early", 32'(outValid), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t1 valid", 32'(outValid), 1);
            check("t1 data", 32'(outData), 32'(12 + 3 * k));
        end
        @(negedge clk);
        check("t1 done", 32'(done), 1);
        check("t1 busy_fall", 32'(busy), 0);
        check("t1 valid_after", 32'(outValid), 0);
        @(negedge clk);
        check("t1 done_one_cycle", 32'(done), 0);
        @(posedge clk);
        #1;

        run_xfer(62, 4, 0, "wrap");
        run_xfer(9, 0, 0, "len0");

        for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
        run_xfer(int'($urandom_range(63)), 64, 1, "full_rand");
        for (int n = 0; n < 4; n++) begin
            run_xfer(int'($urandom_range(63)), int'($urandom_range(64, 1)), 1, "rand");
        end

        // Reset in the third cycle of a length-10 transfer.
        baseAddr = 6'd20;
        length   = 7'd10;
        outReady = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst read_addr", 32'(read_addr), 0);
        check("mid_rst outData", 32'(outData), 0);
        check("mid_rst outValid", 32'(outValid), 0);
        check("mid_rst busy", 32'(busy), 0);
        check("mid_rst done", 32'(done), 0);
        @(posedge clk);
        #1;
        run_xfer(40, 6, 1, "after_rst");

`ifdef RAM_STREAM_READER_ABORT_EN
        begin
            int cyc = 0;
            got.delete();
            done_cnt = 0;
            baseAddr = 6'd10;
            length   = 7'd20;
            outReady = 1'b1;
            start    = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            while (got.size() < 3 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check("abort reached_3", 32'(got.size() >= 3), 1);
            @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            @(negedge clk);
            check("abort outValid", 32'(outValid), 0);
            check("abort busy", 32'(busy), 0);
            repeat (4) @(negedge clk);
            check("abort no_done", 32'(done_cnt), 0);
            @(posedge clk);
            #1;
            run_xfer(30, 2, 0, "post_abort");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
